// File: rtl/boid_pixel_writer_if.sv
// boid_pixel_writer_if: update handshake and frame-buffer write bus for boid_pixel_writer
// Ports (signals): in_valid/in_ready handshake, x/y new and px/py previous 16.16 positions,
// mem_we/mem_waddr/mem_wdata frame-buffer write, done completion pulse.
interface boid_pixel_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] px;
    logic [31:0] py;
    logic        mem_we;
    logic [18:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        done;
    modport master (output in_valid, x, y, px, py, input in_ready, mem_we, mem_waddr, mem_wdata, done);
    modport slave (input in_valid, x, y, px, py, output in_ready, mem_we, mem_waddr, mem_wdata, done);
endinterface

// File: rtl/boid_pixel_writer.sv
// boid_pixel_writer: erases a boid sprite at its previous position and draws it at the new one
// Ports: clk, reset (async active-high), bus (slave: update handshake in, frame-buffer writes and done out).
module boid_pixel_writer #(
    parameter int         SPRITE      = 2,
    parameter logic [7:0] DRAW_COLOR  = 8'hFF,
    parameter logic [7:0] ERASE_COLOR = 8'h00
) (
    input logic               clk,
    input logic               reset,
    boid_pixel_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
    localparam logic [1:0] SMAX = 2'(SPRITE - 1);
    state_t      state_q, state_d;
    logic [1:0]  dc_q, dc_d, dr_q, dr_d;
    logic        first_q, first_d;
    logic [9:0]  col_q, col_d, row_q, row_d, pcol_q, pcol_d, prow_q, prow_d;
    logic [3:0]  clip_q, clip_d;
    logic        mem_we_q, mem_we_d, done_q, done_d;
    logic [18:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        last, erase_n;
    logic [18:0] c, r;
    // Outputs are registered, so the next cycle's pixel is computed from the next-state values.
    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        dr_d    = dr_q;
        first_d = first_q;
        col_d   = col_q;
        row_d   = row_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        clip_d  = clip_q;
        last    = dc_q == SMAX && dr_q == SMAX;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = first_q ? DRAW : ERASE;
                first_d = 1'b0;
                col_d   = bus.x[25:16];
                row_d   = bus.y[25:16];
                pcol_d  = bus.px[25:16];
                prow_d  = bus.py[25:16];
                clip_d  = {|bus.py[31:26], |bus.px[31:26], |bus.y[31:26], |bus.x[31:26]};
            end
            ERASE, DRAW: begin
                dc_d = dc_q == SMAX ? 2'd0 : dc_q + 2'd1;
                dr_d = last ? 2'd0 : dc_q == SMAX ? dr_q + 2'd1 : dr_q;
                state_d = !last ? state_q : state_q == ERASE ? DRAW : DONE;
            end
            DONE: state_d = IDLE;
        endcase
        erase_n  = state_d == ERASE;
        c        = 19'(erase_n ? pcol_d : col_d) + 19'(dc_d);
        r        = 19'(erase_n ? prow_d : row_d) + 19'(dr_d);
        mem_we_d = (state_d == ERASE || state_d == DRAW) && c < 19'd640 && r < 19'd480 &&
                   !(erase_n ? |clip_d[3:2] : |clip_d[1:0]);
        waddr_d  = (r << 9) + (r << 7) + c;
        wdata_d  = erase_n ? ERASE_COLOR : DRAW_COLOR;
        done_d   = state_d == DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dc_q     <= 2'd0;
            dr_q     <= 2'd0;
            first_q  <= 1'b1;
            col_q    <= 10'd0;
            row_q    <= 10'd0;
            pcol_q   <= 10'd0;
            prow_q   <= 10'd0;
            clip_q   <= 4'd0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            waddr_q  <= 19'd0;
            wdata_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            dc_q     <= dc_d;
            dr_q     <= dr_d;
            first_q  <= first_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pcol_q   <= pcol_d;
            prow_q   <= prow_d;
            clip_q   <= clip_d;
            mem_we_q <= mem_we_d;
            done_q   <= done_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_boid_pixel_writer.sv
// tb_boid_pixel_writer: directed self-checking bench for boid_pixel_writer with default parameters
module tb_boid_pixel_writer;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    boid_pixel_writer_if bus();
    boid_pixel_writer dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic we, input logic [18:0] a, input logic [7:0] d,
                        input logic dn, input logic rdy);
        check({tag, ".we"}, 32'(bus.mem_we), 32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(bus.mem_waddr), 32'(a));
            check({tag, ".data"}, 32'(bus.mem_wdata), 32'(d));
        end
        check({tag, ".done"}, 32'(bus.done), 32'(dn));
        check({tag, ".rdy"}, 32'(bus.in_ready), 32'(rdy));
        @(negedge clk);
    endtask
    task automatic sprite(input string tag, input logic [7:0] d, input logic [18:0] a);
        step({tag, "0"}, 1'b1, a, d, 1'b0, 1'b0);
        step({tag, "1"}, 1'b1, a + 19'd1, d, 1'b0, 1'b0);
        step({tag, "2"}, 1'b1, a + 19'd640, d, 1'b0, 1'b0);
        step({tag, "3"}, 1'b1, a + 19'd641, d, 1'b0, 1'b0);
    endtask
    task automatic set_pos(input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] ox,
                           input logic [31:0] oy);
        bus.x  = nx;
        bus.y  = ny;
        bus.px = ox;
        bus.py = oy;
    endtask
    task automatic offer(input string tag, input logic [31:0] nx, input logic [31:0] ny,
                         input logic [31:0] ox, input logic [31:0] oy);
        check({tag, ".accept_rdy"}, 32'(bus.in_ready), 32'd1);
        set_pos(nx, ny, ox, oy);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        set_pos(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask
    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b1;
        set_pos(32'd5 << 16, 32'd5 << 16, 32'd0, 32'd0);
        @(negedge clk);
        step("reset", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        offer("u1", 32'd115 << 16, 32'd319 << 16, 32'd0, 32'd0);
        sprite("u1.d", 8'hFF, 19'd204275);
        step("u1.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        step("u1.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        offer("u2", 32'd119 << 16, 32'd323 << 16, 32'd115 << 16, 32'd319 << 16);
        sprite("u2.e", 8'h00, 19'd204275);
        sprite("u2.d", 8'hFF, 19'd206839);
        step("u2.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        step("u2.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        offer("clip", 32'd639 << 16, 32'd479 << 16, 32'd0, 32'd0);
        step("clip.d0", 1'b1, 19'd307199, 8'hFF, 1'b0, 1'b0);
        step("clip.d1", 1'b0, 19'd0, 8'd0, 1'b0, 1'b0);
        step("clip.d2", 1'b0, 19'd0, 8'd0, 1'b0, 1'b0);
        step("clip.d3", 1'b0, 19'd0, 8'd0, 1'b0, 1'b0);
        step("clip.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        step("clip.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        offer("oor", 32'h0400_0000, 32'd0, 32'd639 << 16, 32'd479 << 16);
        step("oor.e0", 1'b1, 19'd307199, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step($sformatf("oor.s%0d", i + 1), 1'b0, 19'd0, 8'd0, 1'b0, 1'b0);
        step("oor.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        step("oor.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        offer("rst", 32'd50 << 16, 32'd60 << 16, 32'd10 << 16, 32'd10 << 16);
        step("rst.e0", 1'b1, 19'd6410, 8'h00, 1'b0, 1'b0);
        check("rst.e1.we", 32'(bus.mem_we), 32'd1);
        check("rst.e1.addr", 32'(bus.mem_waddr), 32'd6411);
        #2 reset = 1'b1;
        #1 check("rst.async_we", 32'(bus.mem_we), 32'd0);
        check("rst.async_done", 32'(bus.done), 32'd0);
        check("rst.async_rdy", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        set_pos(32'd20 << 16, 32'd5 << 16, 32'd0, 32'd0);
        @(negedge clk);
        step("rst.hold", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        sprite("rst.d", 8'hFF, 19'd3220);
        step("rst.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        step("rst.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        set_pos(32'd100 << 16, 32'd0, 32'd20 << 16, 32'd5 << 16);
        @(negedge clk);
        set_pos(32'd200 << 16, 32'd1 << 16, 32'd100 << 16, 32'd0);
        sprite("b2b.a.e", 8'h00, 19'd3220);
        sprite("b2b.a.d", 8'hFF, 19'd100);
        step("b2b.a.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        step("b2b.a.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        sprite("b2b.b.e", 8'h00, 19'd100);
        sprite("b2b.b.d", 8'hFF, 19'd840);
        step("b2b.b.done", 1'b0, 19'd0, 8'd0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        step("b2b.b.idle", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        step("b2b.no_dup", 1'b0, 19'd0, 8'd0, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
